cfg_chain_loader: RTL and testbench

//  Sequences serial loading of a configuration scan chain that threads through

---
 rtl/cfg_chain_loader_if.sv | 21 ++
 rtl/cfg_chain_loader.sv | 109 ++++++++++
 tb/tb_cfg_chain_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
// Config word stream between the bitstream source and the chain loader.
// The source drives word and valid; the loader answers with ready.
interface cfg_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// Serialises config words LSB-first onto a scan chain head, shifts exactly
// CHAIN_LEN bits, then pulses a commit to the chain storage.
module cfg_chain_loader #(
    parameter  int CHAIN_LEN = 64,
    parameter  int WORD_W    = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1),
    localparam int WC_W      = $clog2(WORD_W + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    cfg_chain_loader_if.slave   stream,
    output logic                cfg_sdo,
    output logic                cfg_en,
    output logic                cfg_latch,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WC_W-1:0]     word_cnt;
    logic [WORD_W-1:0]   shreg;
    logic                last_bit;
    logic                word_end;

    assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign word_end = (word_cnt == WC_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else begin
            state_q <= state_d;
            if (!abort) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) bit_cnt <= '0;
                    end
                    ST_LOAD: begin
                        if (stream.s_valid) begin
                            shreg    <= stream.s_data;
                            word_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        shreg    <= shreg >> 1;
                        word_cnt <= word_cnt + WC_W'(1);
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Abort overrides every transition, including a start seen in IDLE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  if (stream.s_valid) state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (last_bit)      state_d = ST_DONE;
                    else if (word_end) state_d = ST_LOAD;
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stream.s_ready = 1'b0;
        cfg_en         = 1'b0;
        cfg_sdo        = 1'b0;
        cfg_latch      = 1'b0;
        done           = 1'b0;
        busy           = (state_q != ST_IDLE);
        unique case (state_q)
            ST_LOAD:  stream.s_ready = !abort;
            ST_SHIFT: begin
                cfg_en  = !abort;
                cfg_sdo = shreg[0];
            end
            ST_DONE: begin
                cfg_latch = !abort;
                done      = !abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a 16-bit and a 12-bit chain share one stream,
// checked against the LSB-first bit order expected from the offered words.
module tb_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;

    logic sdo_a, en_a, latch_a, busy_a, done_a, ready_a;
    logic sdo_b, en_b, latch_b, busy_b, done_b, ready_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit qa[$];
    bit qb[$];
    int done_cnt_a, latch_cnt_a, done_cyc_a, last_en_a;
    int done_cnt_b, latch_cnt_b, done_cyc_b, last_en_b;

    cfg_chain_loader_if #(.WORD_W(8)) ifa ();
    cfg_chain_loader_if #(.WORD_W(8)) ifb ();

    assign ifa.s_data  = s_data;
    assign ifa.s_valid = s_valid;
    assign ifb.s_data  = s_data;
    assign ifb.s_valid = s_valid;
    assign ready_a = ifa.s_ready;
    assign ready_b = ifb.s_ready;

    cfg_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stream(ifa.slave), .cfg_sdo(sdo_a), .cfg_en(en_a),
        .cfg_latch(latch_a), .busy(busy_a), .done(done_a)
    );

    cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stream(ifb.slave), .cfg_sdo(sdo_b), .cfg_en(en_b),
        .cfg_latch(latch_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en_a) begin qa.push_back(sdo_a); last_en_a = cyc; end
        if (en_b) begin qb.push_back(sdo_b); last_en_b = cyc; end
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
        if (latch_a) latch_cnt_a++;
        if (latch_b) latch_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        qa.delete(); qb.delete();
        done_cnt_a = 0; latch_cnt_a = 0; done_cyc_a = -1; last_en_a = -9;
        done_cnt_b = 0; latch_cnt_b = 0; done_cyc_b = -1; last_en_b = -9;
    endtask

    // Chain image: words concatenated LSB-first, truncated to the chain length.
    function automatic logic [15:0] model(input logic [7:0] w0, input logic [7:0] w1,
                                          input int len);
        logic [15:0] v;
        v = {w1, w0};
        for (int i = len; i < 16; i++) v[i] = 1'b0;
        return v;
    endfunction

    task automatic check_loads(input string tag, input logic [7:0] w0,
                               input logic [7:0] w1);
        logic [15:0] ga, gb, ea, eb;
        ga = '0; gb = '0;
        foreach (qa[i]) if (i < 16) ga[i] = qa[i];
        foreach (qb[i]) if (i < 16) gb[i] = qb[i];
        ea = model(w0, w1, 16);
        eb = model(w0, w1, 12);
        total++;
        if (qa.size() !== 16) begin
            bad++; $display("FAIL %s en_count_a got=%0d want=16", tag, qa.size());
        end
        total++;
        if (ga !== ea) begin
            bad++; $display("FAIL %s sdo_a got=%h want=%h", tag, ga, ea);
        end
        total++;
        if (qb.size() !== 12) begin
            bad++; $display("FAIL %s en_count_b got=%0d want=12", tag, qb.size());
        end
        total++;
        if (gb !== eb) begin
            bad++; $display("FAIL %s sdo_b got=%h want=%h", tag, gb, eb);
        end
        total++;
        if ({done_cnt_a, latch_cnt_a, done_cnt_b, latch_cnt_b} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL %s pulses got=%0d/%0d/%0d/%0d want=1/1/1/1", tag,
                     done_cnt_a, latch_cnt_a, done_cnt_b, latch_cnt_b);
        end
        total++;
        if (done_cyc_a !== last_en_a + 1 || done_cyc_b !== last_en_b + 1) begin
            bad++;
            $display("FAIL %s done_timing got=%0d,%0d want=%0d,%0d", tag,
                     done_cyc_a, done_cyc_b, last_en_a + 1, last_en_b + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total++;
        if ({sdo_a, en_a, latch_a, busy_a, done_a, ready_a} !== 6'b0) begin
            bad++;
            $display("FAIL reset_a got=%b want=000000",
                     {sdo_a, en_a, latch_a, busy_a, done_a, ready_a});
        end
        total++;
        if ({sdo_b, en_b, latch_b, busy_b, done_b, ready_b} !== 6'b0) begin
            bad++;
            $display("FAIL reset_b got=%b want=000000",
                     {sdo_b, en_b, latch_b, busy_b, done_b, ready_b});
        end
    endtask

    // Cycle-exact trace with words 0xA5, 0x3C and s_valid held.
    task automatic test_timing();
        logic [15:0] wv;
        logic [5:0]  ga, ea;
        logic [1:0]  gb, eb;
        bit          ena, enb;
        wv = 16'h3CA5;
        clear_mon();
        tick();
        start = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = 1'b0;
            if (t == 2) s_data = 8'h3C;
            if (t == 11) s_valid = 1'b0;
            #1;
            ena = (t >= 2 && t <= 9) || (t >= 11 && t <= 18);
            enb = (t >= 2 && t <= 9) || (t >= 11 && t <= 14);
            ea = {(t == 1 || t == 10), ena,
                  ena ? wv[(t <= 9) ? t - 2 : t - 3] : 1'b0,
                  (t == 19), (t == 19), (t >= 1 && t <= 19)};
            ga = {ready_a, en_a, en_a & sdo_a, done_a, latch_a, busy_a};
            eb = {enb, (t == 15)};
            gb = {en_b, done_b};
            total++;
            if (ga !== ea) begin
                bad++; $display("FAIL timing_a t=%0d got=%b want=%b", t, ga, ea);
            end
            total++;
            if (gb !== eb) begin
                bad++; $display("FAIL timing_b t=%0d got=%b want=%b", t, gb, eb);
            end
        end
        check_loads("timing", 8'hA5, 8'h3C);
    endtask

    task automatic run_load(input string tag, input logic [7:0] w0,
                            input logic [7:0] w1, input int max_gap,
                            input bit poke_start);
        logic [7:0] wl[2];
        int idx, gap;
        bit ok;
        wl[0] = w0; wl[1] = w1;
        clear_mon();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; ok = 0;
        gap = $urandom_range(0, max_gap);
        for (int c = 0; c < 300; c++) begin
            if (idx < 2 && gap == 0) begin
                s_valid = 1'b1; s_data = wl[idx];
            end else begin
                s_valid = 1'b0; s_data = 8'($urandom);
            end
            start = poke_start && idx < 2 && c > 0 && ($urandom_range(0, 2) == 0);
            #1;
            if (s_valid && ready_a) begin
                idx++;
                gap = $urandom_range(0, max_gap);
            end else if (gap > 0) begin
                gap--;
            end
            tick();
            if (!busy_a) begin ok = 1; break; end
        end
        start = 1'b0; s_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s timeout got=busy want=idle", tag);
        end
        tick(); tick();
        check_loads(tag, w0, w1);
    endtask

    task automatic test_truncate();
        run_load("truncate", 8'hFF, 8'h0F, 0, 0);
    endtask

    task automatic test_stall();
        run_load("stall", 8'hA5, 8'h3C, 5, 0);
    endtask

    task automatic test_abort();
        clear_mon();
        tick();
        start = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
        for (int t = 1; t <= 13; t++) begin
            tick();
            start = 1'b0;
            if (t == 2) s_data = 8'hC3;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        #1;
        total++;
        if ({en_a, busy_a, done_a, latch_a, en_b, busy_b, done_b, latch_b} !== 8'b0) begin
            bad++;
            $display("FAIL abort_idle got=%b want=00000000",
                     {en_a, busy_a, done_a, latch_a, en_b, busy_b, done_b, latch_b});
        end
        tick(); tick();
        total++;
        if (done_cnt_a + latch_cnt_a + done_cnt_b + latch_cnt_b !== 0 || qa.size() >= 16) begin
            bad++;
            $display("FAIL abort_nolatch got=done%0d,en%0d want=done0,en<16",
                     done_cnt_a, qa.size());
        end
        run_load("after_abort", 8'($urandom), 8'($urandom), 2, 0);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        tick();
        start = 1'b1; s_valid = 1'b1; s_data = 8'h96;
        for (int t = 1; t <= 5; t++) begin
            tick();
            start = (t == 3);
        end
        rst_n = 1'b0; start = 1'b0;
        tick();
        rst_n = 1'b1; s_valid = 1'b0;
        #1;
        total++;
        if ({sdo_a, en_a, latch_a, busy_a, done_a, ready_a,
             sdo_b, en_b, latch_b, busy_b, done_b, ready_b} !== 12'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b want=0", {sdo_a, en_a, latch_a, busy_a,
                     done_a, ready_a, sdo_b, en_b, latch_b, busy_b, done_b, ready_b});
        end
        tick(); tick();
        total++;
        if (latch_cnt_a + latch_cnt_b !== 0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_nolatch got=%0d,%b want=0,0", latch_cnt_a + latch_cnt_b, busy_a);
        end
        run_load("after_reset", 8'($urandom), 8'($urandom), 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_load($sformatf("rand%0d", n), 8'($urandom), 8'($urandom), 4, 1);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_truncate();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
